mac_accumulator: RTL

Streaming multiply-accumulate stage that sits directly upstream of the output quantizer. It consumes signed DATA_WIDTH operand pairs over a valid/ready stream and accumulates their products into an ACC_WIDTH register. On the beat flagged last, it emits one ACC_WIDTH dot-product result. The quantizer then narrows that result to DATA_WIDTH.

---
 rtl/mac_accumulator.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: streaming signed multiply-accumulate stage feeding the
// output quantizer. Build with ACC_SAT_EN defined to clamp the accumulator
// and report overflow; otherwise it wraps and out_overflow stays 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand beat handshake
//   in_a, in_b               signed DATA_WIDTH operands
//   in_last                  final beat of the current dot product
//   out_valid/out_ready      result handshake
//   out_data                 signed ACC_WIDTH dot-product result
//   out_count                beats in the result, saturating at MAX_LEN
//   out_overflow             a clamp happened within this dot product
module mac_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_LEN    = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_a,
    input  logic [DATA_WIDTH-1:0]          in_b,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
    output logic                           out_overflow
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_d;
    logic [CW-1:0]                 cnt_q;
    logic [CW-1:0]                 cnt_d;
    logic                          ovf_q;
    logic                          ovf_d;

    logic                          out_valid_q;
    logic [ACC_WIDTH-1:0]          out_data_q;
    logic [CW-1:0]                 out_count_q;
    logic                          out_ovf_q;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    base;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic                           in_fire;

    // A pending result blocks input unless it leaves this same cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    assign prod     = $signed(in_a) * $signed(in_b);
    assign prod_ext = ACC_WIDTH'(prod);

    // A fresh dot product starts from zero regardless of leftover acc.
    assign base = (state_q == ACCUM) ? acc_q : '0;
    assign sum  = base + prod_ext;

    assign cnt_d = (cnt_q == CW'(MAX_LEN)) ? cnt_q : cnt_q + CW'(1);

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic ovf_now;

    always_comb begin
        ovf_now = (base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        acc_d   = sum;
        if (ovf_now) begin
            acc_d = base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
        ovf_d = ((state_q == ACCUM) && ovf_q) || ovf_now;
    end
`else
    // Wrapping build: the sticky flag is never raised.
    always_comb begin
        acc_d = sum;
        ovf_d = ovf_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (in_fire) begin
                if (in_last) begin
                    // Overrides the clear above when a result is replaced.
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_d;
                    out_count_q <= cnt_d;
                    out_ovf_q   <= ovf_d;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    state_q     <= IDLE;
                end else begin
                    acc_q       <= acc_d;
                    cnt_q       <= cnt_d;
                    ovf_q       <= ovf_d;
                    state_q     <= ACCUM;
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule
